cost_matrix_loader: RTL and testbench

Upstream stage of the job-assignment engine. Accepts the 8x8 worker/job cost matrix as a 64-beat valid/ready stream, in row-major order, and stores it. Once full, it serves the engine's combinational cost lookup: W,J in, Cost out in the same cycle. While loading, it also computes the sum of row minima (LowerBound), which is a pruning bound for the assignment search.

---
 rtl/cost_matrix_loader.sv | 109 ++++++++++
 tb/tb_cost_matrix_loader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cost_matrix_loader.sv
// cost_matrix_loader
// Receives an N x N cost matrix as a row-major valid/ready stream and stores it.
// Once the matrix is complete it offers a same-cycle cost lookup and the sum of
// the row minima (LowerBound), which the assignment search uses for pruning.
module cost_matrix_loader #(
   parameter int N      = 8,
   parameter int COST_W = 7,
   parameter int SUM_W  = 10
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [COST_W-1:0]        in_data,
   input  logic                     in_last,
   output logic                     Loaded,
   output logic                     Err,
   input  logic [$clog2(N)-1:0]     W,
   input  logic [$clog2(N)-1:0]     J,
   output logic [COST_W-1:0]        Cost,
   output logic [SUM_W-1:0]         LowerBound
);

   localparam int LOG_N  = $clog2(N);
   localparam int LOG_NN = 2 * LOG_N;
   localparam int NN     = N * N;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]        state;
   logic [LOG_NN-1:0] beat_cnt;
   logic [COST_W-1:0] row_min;
   logic [COST_W-1:0] new_min;
   logic [SUM_W-1:0]  acc;
   logic              err_q;
   logic              accept;
   logic              last_beat;
   logic [LOG_N-1:0]  col;

   logic [COST_W-1:0] mem [NN];

   assign in_ready  = (state == ST_LOAD);
   assign Loaded    = (state == ST_FULL);
   assign Err       = err_q;
   assign accept    = in_valid && in_ready;
   assign last_beat = (beat_cnt == LOG_NN'(NN - 1));
   assign col       = beat_cnt[LOG_N-1:0];

   // Running minimum of the current row including the beat on the bus.
   always_comb begin
      // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
      new_min = row_min;
      if (col == '0)
         new_min = in_data;
      else if (in_data < row_min)
         new_min = in_data;
   end

   // Load sequencing: state, beat counter, row minimum, bound accumulator, error flag.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (RST || clear) begin
         state    <= ST_EMPTY;
         beat_cnt <= '0;
         row_min  <= '0;
         acc      <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            ST_EMPTY: state <= ST_LOAD;
            ST_LOAD: begin
               if (accept) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  row_min  <= new_min;
                  if (col == LOG_N'(N - 1))
                     acc <= acc + SUM_W'(new_min);
                  if (in_last != last_beat)
                     err_q <= 1'b1;
                  if (last_beat)
                     state <= ST_FULL;
               end
            end
            ST_FULL: state <= ST_FULL;
            default: state <= ST_EMPTY;
         endcase
      end
   end

   // Matrix storage write port; a beat dropped by clear or RST is not stored.
   always_ff @(posedge CLK) begin
      // NOTE: the storage array has no reset; Loaded gates every read, so stale contents are never visible.
      if (accept && !clear && !RST)
         mem[beat_cnt] <= in_data;
   end

   // Same-cycle lookup; N is a power of two so {W, J} is the row-major address.
   always_comb begin
      Cost       = '0;
      LowerBound = '0;
      if (Loaded) begin
         Cost       = mem[{W, J}];
         LowerBound = acc;
      end
   end

endmodule

// File: tb/tb_cost_matrix_loader.sv
// tb_cost_matrix_loader
// Directed bench: reset, full loads with and without gaps, abort, protocol
// error and clear colliding with the final beat.
module tb_cost_matrix_loader;

   localparam int N      = 8;
   localparam int COST_W = 7;
   localparam int SUM_W  = 10;
   localparam int NN     = N * N;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              clear = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [COST_W-1:0] in_data = '0;
   logic              in_last = 1'b0;
   logic              Loaded;
   logic              Err;
   logic [2:0]        W = '0;
   logic [2:0]        J = '0;
   logic [COST_W-1:0] Cost;
   logic [SUM_W-1:0]  LowerBound;

   int total = 0;
   int bad   = 0;

   cost_matrix_loader #(.N(N), .COST_W(COST_W), .SUM_W(SUM_W)) dut (
      .CLK(CLK), .RST(RST), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .Loaded(Loaded), .Err(Err), .W(W), .J(J), .Cost(Cost), .LowerBound(LowerBound)
   );

   // 10 ns clock period.
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // mode 0: 3 on the diagonal, 10 elsewhere; mode 1: all 127.
   function automatic logic [COST_W-1:0] entry(input int mode, input int k);
      if (mode == 1) return 7'd127;
      return ((k / N) == (k % N)) ? 7'd3 : 7'd10;
   endfunction

   task automatic wait_ready();
      int c = 0;
      while (!in_ready && c < 50) begin
         tick();
         c++;
      end
      if (!in_ready) check("ready_timeout", in_ready, 1);
   endtask

   // Offers nbeats beats; err_beat >= 0 moves in_last to that beat instead of beat 63.
   task automatic load(input int mode, input bit gaps, input int nbeats, input int err_beat);
      for (int k = 0; k < nbeats; k++) begin
         if (gaps) begin
            in_valid = 1'b0;
            in_data  = 7'h55;
            tick();
         end
         in_valid = 1'b1;
         in_data  = entry(mode, k);
         in_last  = (err_beat >= 0) ? (k == err_beat) : (k == NN - 1);
         wait_ready();
         if (k == NN - 1) check("loaded_low_before_last", Loaded, 0);
         if (err_beat >= 0 && k == err_beat) check("err_low_before_bad_beat", Err, 0);
         tick();
         if (err_beat >= 0 && k == err_beat) check("err_after_bad_beat", Err, 1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic check_cost(input string tag, input int w, input int j, input int exp);
      W = 3'(w);
      J = 3'(j);
      #1;
      check(tag, Cost, exp);
   endtask

   initial begin
      // 1. Reset
      tick();
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_loaded", Loaded, 0);
      check("rst_err", Err, 0);
      check("rst_cost", Cost, 0);
      check("rst_lb", LowerBound, 0);
      RST = 1'b0;
      check("empty_in_ready", in_ready, 0);
      tick();
      check("load_in_ready", in_ready, 1);

      // 2. Full load, continuous valid
      load(0, 1'b0, NN, -1);
      check("t2_loaded", Loaded, 1);
      check("t2_lb", LowerBound, 24);
      check("t2_err", Err, 0);
      check("t2_in_ready", in_ready, 0);
      check_cost("t2_cost_2_2", 2, 2, 3);
      check_cost("t2_cost_2_5", 2, 5, 10);
      check_cost("t2_cost_7_0", 7, 0, 10);

      // 3. Gapped load, then beats offered while FULL
      do_clear();
      check("t3_loaded_after_clear", Loaded, 0);
      load(0, 1'b1, NN, -1);
      check("t3_loaded", Loaded, 1);
      check("t3_lb", LowerBound, 24);
      in_valid = 1'b1;
      in_data  = 7'd99;
      in_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_full_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("t3_full_loaded", Loaded, 1);
      check_cost("t3_cost_0_0", 0, 0, 3);
      check_cost("t3_cost_0_1", 0, 1, 10);
      check("t3_lb_kept", LowerBound, 24);

      // 4. Abort after 20 beats, then all-127 load
      do_clear();
      load(1, 1'b0, 20, -1);
      do_clear();
      check("t4_abort_loaded", Loaded, 0);
      check("t4_abort_in_ready", in_ready, 0);
      check("t4_abort_lb", LowerBound, 0);
      check_cost("t4_abort_cost", 5, 6, 0);
      load(1, 1'b0, NN, -1);
      check("t4_loaded", Loaded, 1);
      check("t4_lb", LowerBound, 1016);
      check_cost("t4_cost_5_6", 5, 6, 127);

      // 5. Protocol error: in_last on beat 10, missing on beat 63
      do_clear();
      check("t5_err_cleared", Err, 0);
      load(0, 1'b0, NN, 10);
      check("t5_loaded", Loaded, 1);
      check("t5_err_kept", Err, 1);
      check("t5_lb", LowerBound, 24);
      tick();
      check("t5_err_still", Err, 1);
      do_clear();
      check("t5_err_after_clear", Err, 0);

      // 6. clear collides with beat 63
      load(0, 1'b0, NN - 1, -1);
      in_valid = 1'b1;
      in_data  = 7'd3;
      in_last  = 1'b1;
      clear    = 1'b1;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("t6_loaded", Loaded, 0);
      check("t6_in_ready", in_ready, 0);
      check("t6_lb", LowerBound, 0);
      for (int i = 0; i < 4; i++) tick();
      check("t6_loaded_never", Loaded, 0);
      load(1, 1'b0, NN, -1);
      check("t6_reload_lb", LowerBound, 1016);
      check("t6_reload_err", Err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
